// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit with the HI/LO register pair (mult, multu, div, divu).
// Optional build macro MULT_EARLY_TERM_EN: MUL exits as soon as the remaining multiplier is zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for Start; mthi/mtlo accepted
// S_MUL   | shift-add, one multiplier bit per cycle
// S_DIV   | restoring division, one quotient bit per cycle
// S_FIXUP | sign correction; Hi/Lo written on exit
// S_DONE  | Done pulse; back-to-back Start accepted here
module mult_div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WriteHi,
   input  logic             WriteLo,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;
   logic                 dbz_q, dbz_d;

   logic                 busy, accept;
   logic                 a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       rem_trial, rem_next;
   logic                 q_bit;
   logic [2*WIDTH-1:0]   prod;

   assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP);
   assign accept = Start && !busy;
   assign a_neg  = !Op[0] && A[WIDTH-1];
   assign b_neg  = !Op[0] && B[WIDTH-1];
   assign a_mag  = a_neg ? -A : A;
   assign b_mag  = b_neg ? -B : B;
   assign b_zero = (B == '0);

   // Dividend bits shift out of mplier_q into the partial remainder held in acc_q.
   assign rem_trial = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
   assign q_bit     = (rem_trial >= {1'b0, mcand_q[WIDTH-1:0]});
   assign rem_next  = q_bit ? (rem_trial - {1'b0, mcand_q[WIDTH-1:0]}) : rem_trial;
   assign prod      = neg_lo_q ? -acc_q : acc_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dbz_d    = dbz_q;

      if (!busy) begin
         if (WriteHi) hi_d = WriteData;
         if (WriteLo) lo_d = WriteData;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               is_div_d = Op[1];
               dbz_d    = Op[1] && b_zero;
               cnt_d    = CW'(WIDTH - 1);
               acc_d    = '0;
               neg_lo_d = a_neg ^ b_neg;
               if (!Op[1]) begin
                  mcand_d  = {{WIDTH{1'b0}}, a_mag};
                  mplier_d = b_mag;
                  neg_hi_d = 1'b0;
                  state_d  = S_MUL;
               end else begin
                  mcand_d  = {{WIDTH{1'b0}}, b_mag};
                  mplier_d = a_mag;
                  neg_hi_d = a_neg;
                  state_d  = b_zero ? S_DONE : S_DIV;
               end
            end
         end
         S_MUL: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
`ifdef MULT_EARLY_TERM_EN
            if ((cnt_q == '0) || (mplier_q[WIDTH-1:1] == '0)) state_d = S_FIXUP;
`else
            if (cnt_q == '0) state_d = S_FIXUP;
`endif
         end
         S_DIV: begin
            acc_d    = {{(WIDTH-1){1'b0}}, rem_next};
            mplier_d = {mplier_q[WIDTH-2:0], q_bit};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (is_div_q) begin
               lo_d = neg_lo_q ? -mplier_q : mplier_q;
               hi_d = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         dbz_q    <= dbz_d;
      end
   end

   assign Busy      = busy;
   assign Done      = (state_q == S_DONE);
   assign DivByZero = (state_q == S_DONE) && dbz_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit with the HI/LO register pair for the MIPS pipeline; services mult, multu, div and divu.
- The EX stage issues an operation with a Start pulse and holds the pipeline on Busy.
- mfhi/mflo read Hi/Lo directly; mthi/mtlo write them through WriteHi/WriteLo.
- Signed and unsigned operation is selected per operation: signed ops sign-extend operands, unsigned ops zero-extend them.

Parameters:
- WIDTH, 32, operand width; Hi/Lo are WIDTH bits each; the full product is 2*WIDTH bits.

Ports:
- Clk  input  1  clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  issue request; sampled only when Busy=0
- Op  input  2  00 mult, 01 multu, 10 div, 11 divu
- A  input  WIDTH  rs operand (multiplicand / dividend)
- B  input  WIDTH  rt operand (multiplier / divisor)
- WriteHi  input  1  mthi strobe
- WriteLo  input  1  mtlo strobe
- WriteData  input  WIDTH  data for mthi/mtlo
- Busy  output  1  operation in flight; EX stage stalls while high
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result in this cycle
- DivByZero  output  1  one-cycle pulse coincident with Done for div/divu with B=0
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0; internal counter and accumulators cleared. Reset mid-operation aborts it with no Done.
- States and transitions:
  - IDLE→MUL on Start with Op[1]=0.
  - IDLE→DIV on Start with Op[1]=1 and B≠0.
  - IDLE→DONE on Start with Op[1]=1 and B=0.
  - MUL/DIV→FIXUP after WIDTH iterations.
  - FIXUP→DONE.
  - DONE→IDLE, or DONE→MUL/DIV/DONE if Start is high (back-to-back issue is allowed in the DONE cycle).
- Load, cycle of Start acceptance: operands are latched. Signed ops store magnitudes and record the result signs. For div the quotient is negative when the operand signs differ, and the remainder takes the sign of the dividend.
- MUL: shift-add, one multiplier bit per cycle. The multiplicand shifts left into a 2*WIDTH accumulator; the multiplier shifts right.
- DIV: restoring division, one quotient bit per cycle.
- FIXUP: applies the sign corrections (two's-complement negate).
  - mult: {Hi,Lo} = product.
  - div: Lo = quotient, Hi = remainder.
- Hi/Lo are written on the FIXUP→DONE edge.
- Busy=1 in MUL, DIV and FIXUP; Busy=0 in IDLE and DONE.
- Done=1 only in the DONE state.
- Latency with Start accepted at edge t0: Busy is high for cycles t0+1 .. t0+WIDTH+1; Done is high in cycle t0+WIDTH+2. This is 34 cycles for WIDTH=32.
- Divide by zero: Hi/Lo are unchanged. Done=DivByZero=1 in cycle t0+1 and Busy is never asserted.
- Overflow: div 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000 and Hi=0 (quotient wraps); no flag.
- Start while Busy=1 is ignored with no queueing. Operands are used only in the acceptance cycle.
- WriteHi/WriteLo:
  - Take effect at the next edge when Busy=0.
  - Ignored while Busy=1.
  - If asserted in the same cycle as an accepted Start, the write lands first and the operation result later overwrites it.
  - If both are asserted, both registers are written.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in MUL, when the remaining shifted multiplier is zero, the next state is FIXUP immediately, regardless of the iteration count. Minimum MUL occupancy is one cycle; a multiplier magnitude of 0 still takes one MUL cycle.
- Undefined: MUL always takes exactly WIDTH cycles.
- DIV timing is unaffected either way.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=7 → Done at t0+34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 33 cycles.
- divu A=100, B=7 → Lo=14, Hi=2; div A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- div A=5, B=0 with Hi=0x11, Lo=0x22 preloaded via mthi/mtlo → Done=DivByZero=1 at t0+1; Hi=0x11, Lo=0x22 unchanged.
- div A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0; then in the Done cycle issue multu 0xFFFFFFFF*0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- multu 6*7 issued; at t0+5 pulse Start (div) and WriteHi=0xAB → both ignored; Reset at t0+10 → next cycle Busy=0, Hi=Lo=0, no Done.
- With MULT_EARLY_TERM_EN: multu A=3, B=5 → Done at t0+5, Lo=15, Hi=0. Without the macro, the same operation gives Done at t0+34.
